// File: rtl/fxp_multiplier_pkg.sv
// Shared definitions for the sign-magnitude fixed-point multiplier:
// default widths, derived accumulator width and the handshake state enum.
package fxp_multiplier_pkg;

    // Default operand width: 1 sign bit + 15 magnitude bits.
    localparam int N_DEFAULT    = 16;
    // Default number of fraction bits inside the magnitude.
    localparam int FRAC_DEFAULT = 12;

    // The magnitude product of two (n-1)-bit magnitudes needs 2*(n-1) bits.
    function automatic int acc_width(input int n);
        return 2 * (n - 1);
    endfunction

    localparam int ACC_W_DEFAULT = acc_width(N_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential shift-add multiplier over W-bit magnitudes.
// Multiplier bits are consumed MSB first, so the accumulator is shifted left
// and conditionally added to each iteration; W iterations, then o_done for
// one enabled cycle while the counter sits at zero.
module shift_add_multiplier #(
    parameter int W = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_enable,
    input  logic           i_start,
    input  logic [W-1:0]   i_a_mag,
    input  logic [W-1:0]   i_b_mag,
    output logic           o_busy,
    output logic           o_done,
    output logic [2*W-1:0] o_acc
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] w_addend;
    logic [2*W-1:0] w_acc_next;

    // One iteration: shift the partial product and add A when the current
    // (top) multiplier bit is set.
    always_comb begin
        w_addend   = r_b[W-1] ? {{W{1'b0}}, r_a} : '0;
        w_acc_next = {r_acc[2*W-2:0], 1'b0} + w_addend;
    end

    // Operand capture, iteration counter and accumulator; everything holds
    // while i_enable is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_acc  <= '0;
        end else if (i_enable) begin
            if (i_start) begin
                r_a    <= i_a_mag;
                r_b    <= i_b_mag;
                r_cnt  <= CW'(W);
                r_busy <= 1'b1;
                r_acc  <= '0;
            end else if (r_busy) begin
                if (r_cnt != '0) begin
                    r_acc <= w_acc_next;
                    r_b   <= {r_b[W-2:0], 1'b0};
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == '0);
    assign o_acc  = r_acc;

endmodule

// File: rtl/fxp_multiplier.sv
// Sign-magnitude fixed-point multiplier with accept/ready handshake.
// The magnitude product comes from the sequential shift-add core; sign,
// truncation/saturation and the IDLE/BUSY/DONE handshake live here.
module fxp_multiplier
    import fxp_multiplier_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int FRAC = FRAC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         accept_in,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         accept_out,
    output logic         ready_out,
    output logic [N-1:0] prod
);
    localparam int MAG_W = N - 1;
    localparam int ACC_W = acc_width(N);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_start;
    logic             w_finish;
    logic             w_sub_busy;
    logic             w_sub_done;
    logic             r_sign;
    logic [N-1:0]     r_prod;
    logic [ACC_W-1:0] w_acc;
    logic [ACC_W-1:0] w_acc_scaled;
    logic [MAG_W-1:0] w_mag_sat;
    logic             w_overflow;
    logic             w_sign;

    shift_add_multiplier #(
        .W (MAG_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .i_enable (enable),
        .i_start  (w_start),
        .i_a_mag  (A[MAG_W-1:0]),
        .i_b_mag  (B[MAG_W-1:0]),
        .o_busy   (w_sub_busy),
        .o_done   (w_sub_done),
        .o_acc    (w_acc)
    );

    // Next-state logic: accept from IDLE/DONE, finish when the core is done.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (accept_in) begin
                        w_state_next = ST_BUSY;
                        w_start      = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_sub_busy && w_sub_done) begin
                        w_state_next = ST_DONE;
                        w_finish     = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (accept_in) begin
                        w_state_next = ST_BUSY;
                        w_start      = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Result formatting: drop FRAC fraction bits (truncate), saturate if any
    // bit remains above the magnitude field, and never emit negative zero.
    always_comb begin
        w_acc_scaled = w_acc >> FRAC;
        w_overflow   = |(w_acc_scaled >> MAG_W);
        w_mag_sat    = w_overflow ? {MAG_W{1'b1}} : w_acc_scaled[MAG_W-1:0];
        w_sign       = r_sign && (w_mag_sat != '0);
    end

    // State, captured result sign and product register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sign  <= 1'b0;
            r_prod  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_sign <= A[N-1] ^ B[N-1];
            end
            if (w_finish) begin
                r_prod <= {w_sign, w_mag_sat};
            end
        end
    end

    assign accept_out = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign ready_out  = (r_state == ST_DONE);
    assign prod       = r_prod;

endmodule

// File: tb/tb_fxp_multiplier.sv
// Self-checking bench for fxp_multiplier: directed vectors, randomized ops
// against an arithmetic reference, stall, mid-operation reset, back-to-back.
module tb_fxp_multiplier;
    localparam int N    = 16;
    localparam int FRAC = 12;
    localparam int LAT  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        accept_in;
    logic [15:0] A;
    logic [15:0] B;
    logic        accept_out;
    logic        ready_out;
    logic [15:0] prod;

    int errors = 0;
    int checks = 0;

    fxp_multiplier #(.N(N), .FRAC(FRAC)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .accept_in  (accept_in),
        .A          (A),
        .B          (B),
        .accept_out (accept_out),
        .ready_out  (ready_out),
        .prod       (prod)
    );

    always #5 clk = ~clk;

    // Reference: real-valued product of Q3.12 magnitudes, truncated,
    // clamped to the largest magnitude, sign cleared on zero.
    function automatic logic [15:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
        longint ma;
        longint mb;
        longint q;
        logic [14:0] m;
        logic s;
        ma = longint'(a[14:0]);
        mb = longint'(b[14:0]);
        q  = (ma * mb) / 4096;
        if (q > 32767) q = 32767;
        m = q[14:0];
        s = (a[15] ^ b[15]) && (q != 0);
        return {s, m};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start one op, scramble A/B and pulse accept_in during BUSY, optionally
    // drop enable for stall_len edges after stall_after edges; report result.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input int stall_after, input int stall_len,
                         output logic [15:0] p, output int lat, output bit busy_ok);
        A = a; B = b; accept_in = 1'b1; enable = 1'b1;
        tick();
        lat = -1; p = '0; busy_ok = 1'b1;
        for (int e = 1; e <= 64; e++) begin
            A = 16'($urandom);
            B = 16'($urandom);
            enable = !(e > stall_after && e <= stall_after + stall_len);
            accept_in = (e < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (ready_out) begin
                lat = e;
                p = prod;
                break;
            end
            if (accept_out) busy_ok = 1'b0;
        end
        accept_in = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; accept_in = 1'b0; A = '0; B = '0;
        #12;
        checks++; if (accept_out !== 1'b1) begin errors++; $display("FAIL reset_accept_out: got %b expected 1", accept_out); end
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready_out: got %b expected 0", ready_out); end
        checks++; if (prod !== 16'h0000) begin errors++; $display("FAIL reset_prod: got %h expected 0000", prod); end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed;
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic [15:0] ve [6];
        logic [15:0] p;
        int lat;
        bit busy_ok;
        va = '{16'h1800, 16'h9800, 16'h0000, 16'h7000, 16'h0001, 16'h1000};
        vb = '{16'h2000, 16'h2000, 16'h9000, 16'h2000, 16'h0001, 16'h1000};
        ve = '{16'h3000, 16'hB000, 16'h0000, 16'h7FFF, 16'h0000, 16'h1000};
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], 0, 0, p, lat, busy_ok);
            checks++; if (p !== ve[i]) begin errors++; $display("FAIL directed_prod[%0d]: got %h expected %h", i, p, ve[i]); end
            checks++; if (lat != LAT) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            checks++; if (!busy_ok) begin errors++; $display("FAIL directed_busy_accept_out[%0d]: accept_out high during BUSY", i); end
            tick();
            checks++; if (ready_out !== 1'b0 || accept_out !== 1'b1) begin errors++; $display("FAIL directed_pulse[%0d]: ready_out=%b accept_out=%b expected 0/1", i, ready_out, accept_out); end
            checks++; if (prod !== ve[i]) begin errors++; $display("FAIL directed_hold[%0d]: got %h expected %h", i, prod, ve[i]); end
            $display("directed %0d: %h * %h -> %h (lat %0d)", i, va[i], vb[i], p, lat);
        end
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic [15:0] p;
        int lat;
        bit busy_ok;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 2 == 1) b = b & 16'h8FFF;
            exp = ref_mult(a, b);
            do_op(a, b, 0, 0, p, lat, busy_ok);
            checks++; if (p !== exp) begin errors++; $display("FAIL random_prod[%0d]: %h*%h got %h expected %h", i, a, b, p, exp); end
            checks++; if (lat != LAT) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            checks++; if (!busy_ok) begin errors++; $display("FAIL random_busy_accept_out[%0d]: accept_out high during BUSY", i); end
            $display("random %0d: %h * %h -> %h (lat %0d)", i, a, b, p, lat);
            tick();
        end
    endtask

    task automatic test_stall;
        logic [15:0] p;
        int lat;
        bit busy_ok;
        do_op(16'h1800, 16'h2000, 6, 5, p, lat, busy_ok);
        checks++; if (p !== 16'h3000) begin errors++; $display("FAIL stall_prod: got %h expected 3000", p); end
        checks++; if (lat != LAT + 5) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", lat, LAT + 5); end
        tick();
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL stall_single_pulse: got %b expected 0", ready_out); end
        $display("stall: 1800 * 2000 -> %h (lat %0d)", p, lat);
    endtask

    task automatic test_reset_mid;
        logic [15:0] p;
        int lat;
        bit busy_ok;
        bit seen;
        do_op(16'h1800, 16'h2000, 0, 0, p, lat, busy_ok);
        tick();
        A = 16'h1800; B = 16'h2000; accept_in = 1'b1; enable = 1'b1;
        tick();
        accept_in = 1'b0;
        repeat (7) tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (accept_out !== 1'b1) begin errors++; $display("FAIL midreset_accept_out: got %b expected 1", accept_out); end
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL midreset_ready_out: got %b expected 0", ready_out); end
        checks++; if (prod !== 16'h0000) begin errors++; $display("FAIL midreset_prod: got %h expected 0000", prod); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (ready_out) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midreset_no_ready: got ready_out pulse expected none"); end
        do_op(16'h1000, 16'h1000, 0, 0, p, lat, busy_ok);
        checks++; if (p !== 16'h1000) begin errors++; $display("FAIL midreset_next_prod: got %h expected 1000", p); end
        checks++; if (lat != LAT) begin errors++; $display("FAIL midreset_next_latency: got %0d expected %0d", lat, LAT); end
        $display("reset mid-busy then 1000 * 1000 -> %h (lat %0d)", p, lat);
        tick();
    endtask

    task automatic test_back_to_back;
        logic [15:0] a_cur;
        logic [15:0] b_cur;
        logic [15:0] a_nxt;
        logic [15:0] b_nxt;
        logic [15:0] exp;
        logic        exp_ao;
        int lat;
        bit busy_ok;
        a_cur = 16'h1800; b_cur = 16'h2000;
        A = a_cur; B = b_cur; enable = 1'b1; accept_in = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                a_nxt = 16'($urandom); b_nxt = 16'($urandom) & 16'h8FFF;
            end else begin
                a_nxt = 16'h9800; b_nxt = 16'h2000;
            end
            A = a_nxt; B = b_nxt;
            lat = -1; busy_ok = 1'b1;
            for (int e = 1; e <= 40; e++) begin
                tick();
                if (ready_out) begin
                    lat = e;
                    break;
                end
                if (accept_out) busy_ok = 1'b0;
            end
            exp = ref_mult(a_cur, b_cur);
            checks++; if (prod !== exp) begin errors++; $display("FAIL b2b_prod[%0d]: got %h expected %h", i, prod, exp); end
            checks++; if (lat != LAT) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            checks++; if (!busy_ok) begin errors++; $display("FAIL b2b_busy_accept_out[%0d]: accept_out high during BUSY", i); end
            $display("b2b %0d: %h * %h -> %h (lat %0d)", i, a_cur, b_cur, prod, lat);
            if (i == 5) accept_in = 1'b0;
            exp_ao = (i == 5);
            tick();
            checks++; if (accept_out !== exp_ao || ready_out !== 1'b0) begin errors++; $display("FAIL b2b_restart[%0d]: accept_out=%b ready_out=%b expected %b/0", i, accept_out, ready_out, exp_ao); end
            a_cur = a_nxt; b_cur = b_nxt;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fxp_multiplier.md
FXP_MULTIPLIER -- requirements
Module: fxp_multiplier

Interface
REQ-001 SHALL have parameter N, default 16, total operand/result width (1 sign bit + N-1 magnitude bits).
REQ-002 SHALL have parameter FRAC, default 12, number of fraction bits in the magnitude.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  global advance; when low all state, including DONE, holds.
REQ-006 SHALL have port accept_in  input  1  start request, qualified by accept_out and enable.
REQ-007 SHALL have port A  input  N  multiplicand, sign-magnitude, bit N-1 sign, Q(N-1-FRAC).FRAC magnitude.
REQ-008 SHALL have port B  input  N  multiplier, same format as A.
REQ-009 SHALL have port accept_out  output  1  high when a new operation can be accepted (IDLE or DONE).
REQ-010 SHALL have port ready_out  output  1  one-cycle pulse marking prod valid.
REQ-011 SHALL have port prod  output  N  product A*B, same sign-magnitude format, held until next result.

Function
REQ-012 States: IDLE, BUSY, DONE; SHALL leave state only on edges where enable=1.
REQ-013 IDLE/DONE + accept_in=1 + enable=1 SHALL capture A, B, clear accumulator, load counter=N-1, go BUSY.
REQ-014 accept_in while BUSY SHALL be ignored; operands captured at start SHALL be used regardless of later A/B changes.
REQ-015 BUSY SHALL perform one shift-add iteration per enabled cycle over the N-1 magnitude bits of B, 2*(N-1)-bit accumulator.
REQ-016 After the (N-1)th iteration (counter reaches 0) SHALL go DONE; with enable held high, ready_out asserts exactly N clock edges after the accepting edge (16 for defaults).
REQ-017 ready_out SHALL be high exactly one enabled cycle in DONE; DONE with no accept_in returns to IDLE next enabled edge; DONE with accept_in starts a new op directly (back-to-back).
REQ-018 Magnitude result SHALL be accumulator bits [FRAC+N-2:FRAC], truncation toward zero, no rounding.
REQ-019 If any accumulator bit above FRAC+N-2 is 1, magnitude SHALL saturate to all ones (0x7FFF for defaults).
REQ-020 Sign SHALL be A[N-1] XOR B[N-1], except a zero magnitude result SHALL have sign 0 (no negative zero).
REQ-021 prod SHALL update only on entry to DONE and hold its value through IDLE and subsequent BUSY.
REQ-022 enable low mid-BUSY SHALL freeze counter and accumulator; the result SHALL equal the unstalled result, latency extended by stalled cycles.

Reset
REQ-023 reset=1 SHALL asynchronously force IDLE, accept_out=1, ready_out=0, prod=0, counter=0, accumulator=0.
REQ-024 reset during BUSY or DONE SHALL abort the operation with no ready_out pulse; first accept after release starts cleanly.

Structure
REQ-025 Shared package SHALL hold N/FRAC defaults, derived accumulator width, and the state enum.
REQ-026 Magnitude shift-add datapath SHALL be a sub-module shift_add_multiplier (generic width, start/busy/done); sign, saturation and handshake in the top.
REQ-027 Design SHALL be fully synchronous except the reset; no combinational path from A/B to prod.

Verification
REQ-028 A=0x1800 (1.5), B=0x2000 (2.0), accept -> ready_out after 16 edges, prod=0x3000.
REQ-029 A=0x9800 (-1.5), B=0x2000 -> prod=0xB000; A=0x0000, B=0x9000 -> prod=0x0000 (sign cleared).
REQ-030 A=0x7000 (7.0), B=0x2000 -> prod=0x7FFF (saturated); A=0x0001, B=0x0001 -> prod=0x0000 (truncated).
REQ-031 Start 0x1800*0x2000, drop enable for 5 cycles mid-BUSY -> prod=0x3000, ready_out after 21 edges, single pulse.
REQ-032 Assert reset 7 cycles into BUSY -> all outputs reset values immediately, no ready_out; next op 0x1000*0x1000 -> 0x1000.
REQ-033 Hold accept_in high continuously with alternating operands -> back-to-back results every 16 edges, accept_in ignored in BUSY.
